// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // 2'd3 is unused and the FSM sends it back to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } div_state_t;

    // Full-adder cell, the same one the array multiplier is built from.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/seq_divider_div_sub_stage.sv
// One restoring-divider trial subtraction: i_a - i_b as a ripple of full adders
// with the subtrahend inverted and carry-in 1. o_borrow selects the restore path.
module div_sub_stage
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    output logic [WIDTH:0] o_diff,
    output logic           o_borrow
);

    logic [WIDTH+1:0] w_carry;

    assign w_carry[0] = 1'b1;

    // Ripple chain of full-adder cells.
    for (genvar g = 0; g <= WIDTH; g++) begin : g_fa
        assign o_diff[g]      = fa_sum(i_a[g], ~i_b[g], w_carry[g]);
        assign w_carry[g + 1] = fa_carry(i_a[g], ~i_b[g], w_carry[g]);
    end

    // No carry out means i_a < i_b, i.e. the trial result is negative.
    assign o_borrow = ~w_carry[WIDTH + 1];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, registered results held until the next job.
//
// state    | meaning
// S_IDLE   | waiting for start; results from the last job are held
// S_RUN    | shifting and trial-subtracting, one quotient bit per cycle
// S_FINISH | publish results; done pulses in the following cycle
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_dz_flag;
    logic             r_done;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_dz_out;

    logic             w_accept;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;

    // A start coinciding with the done pulse is dropped, forcing one idle cycle.
    assign w_accept = (r_state == S_IDLE) && i_start && !r_done;

    // R is always below the divisor, so its top bit is zero before the shift.
    assign w_rem_sh = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .i_a      (w_rem_sh),
        .i_b      ({1'b0, r_d}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = (i_divisor == '0) ? S_FINISH : S_RUN;
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) w_state_nxt = S_FINISH;
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, shift/subtract datapath and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q       <= '0;
            r_d       <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dz_flag <= 1'b0;
            r_done    <= 1'b0;
            r_quo     <= '0;
            r_rem_out <= '0;
            r_dz_out  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_q       <= i_dividend;
                        r_d       <= i_divisor;
                        r_rem     <= '0;
                        r_cnt     <= CW'(WIDTH);
                        r_dz_flag <= (i_divisor == '0);
                    end
                end
                S_RUN: begin
                    r_rem <= w_borrow ? w_rem_sh : w_diff;
                    r_q   <= {r_q[WIDTH-2:0], ~w_borrow};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FINISH: begin
                    r_done   <= 1'b1;
                    r_dz_out <= r_dz_flag;
                    if (r_dz_flag) begin
                        r_quo     <= '1;
                        r_rem_out <= r_q;
                    end else begin
                        r_quo     <= r_q;
                        r_rem_out <= r_rem[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_quotient    = r_quo;
    assign o_remainder   = r_rem_out;
    assign o_div_by_zero = r_dz_out;

endmodule
